maze_dfs_ctrl: RTL and testbench
================================

Name: maze_dfs_ctrl

Overview:
- Depth-first rat-in-maze solver controller.
- Sequences the shared path stack/queue: push, pop, done and run strobes. Reads and marks a 16x16 maze cell memory.
- On success, switches the stack to queue mode and streams the path out, start to goal.
- Sits between the top-level testbench or host and the path-store and maze-memory datapath.

Parameters:
- START_X, 0, start column (4 bits)
- START_Y, 0, start row (4 bits)
- GOAL_X, 15, goal column
- GOAL_Y, 15, goal row

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begin solve
- mem_addr  out  8  cell address {x[3:0], y[3:0]}
- mem_rd_data  in  2  {visited, wall}; valid 1 cycle after mem_addr (synchronous read)
- mem_wr_en  out  1  set visited bit of the cell at mem_addr
- stk_push  out  1  push stk_loc_in
- stk_pop  out  1  pop request
- stk_done  out  1  switch stack to queue readout
- stk_run  out  1  enable queue-mode pop
- stk_loc_in  out  8  location to push {x, y}
- stk_loc_out  in  8  popped location; valid the cycle after stk_pop
- stk_empty  in  1  stack/queue empty flag
- busy  out  1  solve or readout in progress
- found  out  1  sticky; goal reached
- no_path  out  1  sticky; search exhausted
- path_valid  out  1  path_loc valid this cycle
- path_loc  out  8  path cell, start to goal order

Behaviour:
- Reset: FSM=IDLE. All outputs 0. Internal cur, dir and nbr are 0. Reset mid-operation aborts immediately; the stack shares rst.
- Strobe rules:
  - At most one of stk_push / stk_pop / stk_done is high in any cycle.
  - Every strobe lasts exactly one cycle.
- Directions: 0=E(x+1), 1=S(y+1), 2=W(x-1), 3=N(y-1).
  - A neighbour is out of bounds if the 4-bit add/subtract wraps. Wrap is never followed.
- IDLE: on start, clear found/no_path, cur=START, go to INIT. start while busy is ignored.
- INIT:
  - Assert mem_addr=cur, mem_wr_en=1.
  - Assert stk_push=1, stk_loc_in=cur.
  - If cur==GOAL, go to FOUND; else dir=0, go to PROBE.
- PROBE:
  - Compute nbr(cur, dir).
  - If out of bounds, go to NEXT. Else drive mem_addr=nbr and go to CHECK.
- CHECK:
  - If mem_rd_data==2'b00, go to MOVE; else go to NEXT.
- NEXT:
  - If dir==3, go to BACK1; else dir=dir+1, go to PROBE.
- MOVE:
  - Assert mem_wr_en=1 (mem_addr=nbr).
  - Assert stk_push=1, stk_loc_in=nbr.
  - Set cur=nbr, dir=0.
  - If nbr==GOAL, go to FOUND; else go to PROBE.
- Backtrack:
  - BACK1: stk_pop discards cur. Next state BACK2.
  - BACK2: if stk_empty, set no_path=1 and go to IDLE; else stk_pop, go to BACK3.
  - BACK3: cur=stk_loc_out, go to BACK4.
  - BACK4: stk_push=1, stk_loc_in=cur (parent re-pushed), dir=0, go to PROBE.
  - Visited marks guarantee termination.
- FOUND: found=1, stk_done=1 for one cycle, go to READ.
- READ:
  - While !stk_empty: stk_run=1 and stk_pop=1 every cycle.
  - The cycle after each pop: path_valid=1, path_loc=stk_loc_out.
  - When stk_empty is seen with no pop outstanding, go to IDLE.
- busy=1 in every state except IDLE.
- Cycle cost: probe of one direction = 2 cycles (PROBE+CHECK) plus 1 for NEXT; move = 1 cycle; backtrack = 4 cycles.
- Capacity: the path store holds 255 entries. A push when the depth reaches 255 sets no_path=1 and returns to IDLE (overflow is treated as failure).

Optional Feature:
- Macro: MAZE_STEP_CNT_EN.
- When defined: adds output step_cnt [15:0].
  - Cleared on start.
  - Increments on every MOVE and every BACK1.
  - Saturates at 16'hFFFF.
  - Holds its value after solve ends.
  - Reset value 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package maze_pkg holds:
  - FSM state encoding: IDLE, INIT, PROBE, CHECK, NEXT, MOVE, BACK1-4, FOUND, READ.
  - Direction codes DIR_E/S/W/N.
  - Cell packing helpers for {x, y}.
  - Constants WALL_BIT=0, VISITED_BIT=1, STACK_DEPTH=255.
- Sub-module maze_nbr_calc (combinational):
  - Inputs: cur, dir.
  - Outputs: nbr, oob.
  - Kept separate for reuse and unit test.

Test Plan:
- Open 16x16 maze (all 2'b00), start pulse:
  - found=1.
  - Path streams (0,0),(1,0)...(15,0),(15,1)...(15,15): 31 path_valid beats.
  - no_path=0.
- Wall column at x=8 (all y):
  - no_path=1, found=0, busy drops.
  - No path_valid.
- Dead-end at (1,0) with (0,1) open:
  - Exactly one BACK1-4 sequence.
  - Streamed path starts (0,0),(0,1), with no (1,0) entry.
- START=GOAL=(0,0):
  - found=1 after INIT.
  - Single path_valid with path_loc=8'h00.
- rst asserted mid-MOVE:
  - All outputs 0 the same cycle.
  - A new start pulse solves an open maze correctly.
- With MAZE_STEP_CNT_EN, open maze: step_cnt=30 at finish.

Source files
------------

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types, constants and cell helpers for the maze solver
// Purpose: FSM state encoding, direction codes, {x, y} cell packing helpers and
//          memory/stack constants used by maze_dfs_ctrl and maze_nbr_calc.
// Ports:   none (package).
package maze_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_PROBE, S_CHECK, S_NEXT, S_MOVE,
    S_BACK1, S_BACK2, S_BACK3, S_BACK4, S_FOUND, S_READ
  } state_t;

  typedef enum logic [1:0] {
    DIR_E = 2'd0,
    DIR_S = 2'd1,
    DIR_W = 2'd2,
    DIR_N = 2'd3
  } dir_t;

  localparam int WALL_BIT    = 0;
  localparam int VISITED_BIT = 1;
  localparam int STACK_DEPTH = 255;

  function automatic logic [7:0] pack_cell(input logic [3:0] x, input logic [3:0] y);
    return {x, y};
  endfunction

  function automatic logic [3:0] cell_x(input logic [7:0] c);
    return c[7:4];
  endfunction

  function automatic logic [3:0] cell_y(input logic [7:0] c);
    return c[3:0];
  endfunction

endpackage

// File: rtl/maze_nbr_calc.sv
// rtl/maze_nbr_calc.sv - neighbour cell and out-of-bounds flag for one direction
// Purpose: combinational step from cur in direction dir on the 16x16 grid.
// Ports:   cur [7:0] in  current cell {x, y}
//          dir [1:0] in  direction (E, S, W, N)
//          nbr [7:0] out neighbour cell {x, y}
//          oob       out neighbour falls off the grid (4-bit add/sub wrapped)
module maze_nbr_calc
  import maze_pkg::*;
(
  input  logic [7:0] cur,
  input  dir_t       dir,
  output logic [7:0] nbr,
  output logic       oob
);

  logic [3:0] w_x;
  logic [3:0] w_y;

  assign w_x = cell_x(cur);
  assign w_y = cell_y(cur);

  // The fifth bit of each 5-bit add/subtract is the carry/borrow, i.e. the wrap.
  always_comb begin
    nbr = cur;
    oob = 1'b0;
    case (dir)
      DIR_E: {oob, nbr[7:4]} = {1'b0, w_x} + 5'd1;
      DIR_S: {oob, nbr[3:0]} = {1'b0, w_y} + 5'd1;
      DIR_W: {oob, nbr[7:4]} = {1'b0, w_x} - 5'd1;
      DIR_N: {oob, nbr[3:0]} = {1'b0, w_y} - 5'd1;
      default: oob = 1'b1;
    endcase
  end

endmodule

// File: rtl/maze_dfs_ctrl.sv
// rtl/maze_dfs_ctrl.sv - depth-first rat-in-maze solver controller
// Purpose: walks a 16x16 cell memory depth-first, keeping the current path in an
//          external stack; on reaching the goal flips the stack to queue mode
//          and streams the path start to goal.
// Optional: MAZE_STEP_CNT_EN adds step_cnt (saturating count of moves + backtracks).
// Ports:   clk, rst (async, active-high), start (one-cycle pulse)
//          mem_addr/mem_rd_data/mem_wr_en : cell memory, {visited, wall}, 1-cycle read
//          stk_push/stk_pop/stk_done/stk_run/stk_loc_in/stk_loc_out/stk_empty : path store
//          busy, found, no_path : status; path_valid/path_loc : path stream
module maze_dfs_ctrl
  import maze_pkg::*;
#(
  parameter logic [3:0] START_X = 4'd0,
  parameter logic [3:0] START_Y = 4'd0,
  parameter logic [3:0] GOAL_X  = 4'd15,
  parameter logic [3:0] GOAL_Y  = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] mem_addr,
  input  logic [1:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic       stk_push,
  output logic       stk_pop,
  output logic       stk_done,
  output logic       stk_run,
  output logic [7:0] stk_loc_in,
  input  logic [7:0] stk_loc_out,
  input  logic       stk_empty,
  output logic       busy,
  output logic       found,
  output logic       no_path,
  output logic       path_valid,
  output logic [7:0] path_loc
`ifdef MAZE_STEP_CNT_EN
  ,
  output logic [15:0] step_cnt
`endif
);

  localparam logic [7:0] START_LOC = pack_cell(START_X, START_Y);
  localparam logic [7:0] GOAL_LOC  = pack_cell(GOAL_X, GOAL_Y);

  state_t     r_state;
  logic [7:0] r_cur;
  dir_t       r_dir;
  logic [7:0] r_nbr;
  logic [7:0] r_depth;
  logic       r_found;
  logic       r_no_path;
  logic       r_path_valid;

  logic [7:0] w_nbr;
  logic       w_oob;
  logic       w_full;
  logic       w_cell_open;

  maze_nbr_calc u_nbr (
    .cur (r_cur),
    .dir (r_dir),
    .nbr (w_nbr),
    .oob (w_oob)
  );

  // r_depth mirrors the path store occupancy so overflow is caught before the push.
  assign w_full      = (r_depth == 8'(STACK_DEPTH));
  assign w_cell_open = !mem_rd_data[WALL_BIT] && !mem_rd_data[VISITED_BIT];

  // Strobes decode from registered state so each lasts exactly one state-cycle
  // and PROBE can present the neighbour address in time for CHECK.
  always_comb begin
    mem_addr   = '0;
    mem_wr_en  = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_done   = 1'b0;
    stk_run    = 1'b0;
    stk_loc_in = '0;
    case (r_state)
      S_INIT: begin
        mem_addr   = r_cur;
        mem_wr_en  = 1'b1;
        stk_push   = !w_full;
        stk_loc_in = r_cur;
      end
      S_PROBE: if (!w_oob) mem_addr = w_nbr;
      S_CHECK: mem_addr = r_nbr;
      S_MOVE: begin
        mem_addr   = r_nbr;
        mem_wr_en  = 1'b1;
        stk_push   = !w_full;
        stk_loc_in = r_nbr;
      end
      S_BACK1: stk_pop = 1'b1;
      S_BACK2: stk_pop = !stk_empty;
      S_BACK4: begin
        stk_push   = 1'b1;
        stk_loc_in = r_cur;
      end
      S_FOUND: stk_done = 1'b1;
      S_READ: begin
        stk_run = !stk_empty;
        stk_pop = !stk_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_dir        <= DIR_E;
      r_nbr        <= '0;
      r_depth      <= '0;
      r_found      <= 1'b0;
      r_no_path    <= 1'b0;
      r_path_valid <= 1'b0;
    end else begin
      r_path_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_found   <= 1'b0;
          r_no_path <= 1'b0;
          r_cur     <= START_LOC;
          r_depth   <= '0;
          r_state   <= S_INIT;
        end
        S_INIT: begin
          r_depth <= r_depth + 8'd1;
          if (r_cur == GOAL_LOC) begin
            r_found <= 1'b1;
            r_state <= S_FOUND;
          end else begin
            r_dir   <= DIR_E;
            r_state <= S_PROBE;
          end
        end
        S_PROBE: if (w_oob) begin
          r_state <= S_NEXT;
        end else begin
          r_nbr   <= w_nbr;
          r_state <= S_CHECK;
        end
        S_CHECK: r_state <= w_cell_open ? S_MOVE : S_NEXT;
        S_NEXT: if (r_dir == DIR_N) begin
          r_state <= S_BACK1;
        end else begin
          r_dir   <= dir_t'(r_dir + 2'd1);
          r_state <= S_PROBE;
        end
        S_MOVE: if (w_full) begin
          r_no_path <= 1'b1;
          r_state   <= S_IDLE;
        end else begin
          r_depth <= r_depth + 8'd1;
          r_cur   <= r_nbr;
          r_dir   <= DIR_E;
          if (r_nbr == GOAL_LOC) begin
            r_found <= 1'b1;
            r_state <= S_FOUND;
          end else begin
            r_state <= S_PROBE;
          end
        end
        S_BACK1: begin
          r_depth <= r_depth - 8'd1;
          r_state <= S_BACK2;
        end
        S_BACK2: if (stk_empty) begin
          r_no_path <= 1'b1;
          r_state   <= S_IDLE;
        end else begin
          r_depth <= r_depth - 8'd1;
          r_state <= S_BACK3;
        end
        S_BACK3: begin
          r_cur   <= stk_loc_out;
          r_state <= S_BACK4;
        end
        S_BACK4: begin
          r_depth <= r_depth + 8'd1;
          r_dir   <= DIR_E;
          r_state <= S_PROBE;
        end
        S_FOUND: r_state <= S_READ;
        // Leave only once the last popped entry has been presented.
        S_READ: if (!stk_empty) begin
          r_path_valid <= 1'b1;
        end else if (!r_path_valid) begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MAZE_STEP_CNT_EN
  logic [15:0] r_step_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_cnt <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_step_cnt <= '0;
    end else if ((r_state == S_MOVE || r_state == S_BACK1) && r_step_cnt != 16'hFFFF) begin
      r_step_cnt <= r_step_cnt + 16'd1;
    end
  end

  assign step_cnt = r_step_cnt;
`endif

  assign busy       = (r_state != S_IDLE);
  assign found      = r_found;
  assign no_path    = r_no_path;
  assign path_valid = r_path_valid;
  assign path_loc   = r_path_valid ? stk_loc_out : '0;

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// tb/tb_maze_dfs_ctrl.sv - self-checking bench for maze_dfs_ctrl
module tb_maze_dfs_ctrl;

  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       mem_clear;
  logic       start_s    [2];
  logic [7:0] mem_addr_w [2];
  logic [1:0] rd_w       [2];
  logic       wr_w       [2];
  logic       push_w     [2];
  logic       pop_w      [2];
  logic       done_w     [2];
  logic       run_w      [2];
  logic [7:0] loc_in_w   [2];
  logic [7:0] loc_out_w  [2];
  logic       empty_w    [2];
  logic       busy_w     [2];
  logic       found_w    [2];
  logic       nopath_w   [2];
  logic       pv_w       [2];
  logic [7:0] ploc_w     [2];
`ifdef MAZE_STEP_CNT_EN
  logic [15:0] step_w    [2];
`endif

  logic wall [256];

  int checks = 0;
  int errors = 0;

  logic [7:0] got_path [$];
  logic [7:0] exp_path [$];
  int  got_pushes, got_pops;
  bit  got_timeout;
  bit  exp_found, exp_nopath;
  int  exp_moves, exp_backs, exp_pushes, exp_pops;

  // Instance 0 solves toward (15,15); instance 1 has start == goal == (0,0).
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam logic [3:0] GXY = (g == 0) ? 4'd15 : 4'd0;

    maze_dfs_ctrl #(
      .START_X(4'd0), .START_Y(4'd0), .GOAL_X(GXY), .GOAL_Y(GXY)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start_s[g]),
      .mem_addr(mem_addr_w[g]), .mem_rd_data(rd_w[g]), .mem_wr_en(wr_w[g]),
      .stk_push(push_w[g]), .stk_pop(pop_w[g]), .stk_done(done_w[g]), .stk_run(run_w[g]),
      .stk_loc_in(loc_in_w[g]), .stk_loc_out(loc_out_w[g]), .stk_empty(empty_w[g]),
      .busy(busy_w[g]), .found(found_w[g]), .no_path(nopath_w[g]),
      .path_valid(pv_w[g]), .path_loc(ploc_w[g])
`ifdef MAZE_STEP_CNT_EN
      , .step_cnt(step_w[g])
`endif
    );

    logic       vis [256];
    logic [7:0] stk [256];
    logic [8:0] cnt, head;
    logic       qmode;
    int         viol = 0;

    always @(posedge clk) begin
      if (mem_clear) begin
        for (int i = 0; i < 256; i++) vis[i] <= 1'b0;
      end else if (wr_w[g]) begin
        vis[mem_addr_w[g]] <= 1'b1;
      end
      rd_w[g] <= {vis[mem_addr_w[g]], wall[mem_addr_w[g]]};
    end

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0; head <= '0; qmode <= 1'b0; loc_out_w[g] <= '0;
      end else begin
        if (push_w[g]) begin
          stk[cnt[7:0]] <= loc_in_w[g];
          cnt <= cnt + 9'd1;
        end
        if (pop_w[g]) begin
          if (qmode) begin
            if (run_w[g]) begin
              loc_out_w[g] <= stk[head[7:0]];
              if (head + 9'd1 == cnt) begin
                qmode <= 1'b0; cnt <= '0; head <= '0;
              end else begin
                head <= head + 9'd1;
              end
            end
          end else begin
            loc_out_w[g] <= stk[8'(cnt - 9'd1)];
            cnt <= cnt - 9'd1;
          end
        end
        if (done_w[g]) begin
          qmode <= 1'b1; head <= '0;
        end
      end
    end

    assign empty_w[g] = qmode ? (head == cnt) : (cnt == 9'd0);

    always @(negedge clk) begin
      if (!rst) begin
        if (int'(push_w[g]) + int'(pop_w[g]) + int'(done_w[g]) > 1) viol <= viol + 1;
        if (pop_w[g] && empty_w[g]) viol <= viol + 1;
      end
    end
  end

  // Reference: plain recursive-style DFS over integer coordinates, E,S,W,N order.
  task automatic model_solve(input int sx, input int sy, input int gx, input int gy);
    bit vis [16][16];
    int px [$];
    int py [$];
    int dxs [4] = '{1, 0, -1, 0};
    int dys [4] = '{0, 1, 0, -1};
    int cx, cy, nx, ny;
    bit adv, fin;
    exp_path.delete();
    exp_found = 0; exp_nopath = 0; exp_moves = 0; exp_backs = 0;
    exp_pushes = 1; exp_pops = 0;
    px.push_back(sx); py.push_back(sy); vis[sx][sy] = 1;
    fin = (sx == gx && sy == gy);
    exp_found = fin;
    while (!fin) begin
      cx = px[$]; cy = py[$]; adv = 0; nx = 0; ny = 0;
      for (int d = 0; d < 4 && !adv; d++) begin
        nx = cx + dxs[d]; ny = cy + dys[d];
        if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16)
          if (!wall[nx * 16 + ny] && !vis[nx][ny]) adv = 1;
      end
      if (adv) begin
        exp_moves++;
        if (px.size() == 255) begin
          exp_nopath = 1; fin = 1;
        end else begin
          vis[nx][ny] = 1; px.push_back(nx); py.push_back(ny); exp_pushes++;
          if (nx == gx && ny == gy) begin exp_found = 1; fin = 1; end
        end
      end else begin
        exp_backs++; exp_pops++;
        void'(px.pop_back()); void'(py.pop_back());
        if (px.size() == 0) begin
          exp_nopath = 1; fin = 1;
        end else begin
          exp_pops++; exp_pushes++;
        end
      end
    end
    if (exp_found)
      foreach (px[i]) exp_path.push_back(8'(px[i] * 16 + py[i]));
  endtask

  function automatic int path_diff();
    int n = 0;
    if (got_path.size() != exp_path.size()) return 1000;
    foreach (got_path[i]) if (got_path[i] !== exp_path[i]) n++;
    return n;
  endfunction

  task automatic clear_mem();
    @(negedge clk); mem_clear = 1'b1;
    @(negedge clk); mem_clear = 1'b0;
  endtask

  task automatic set_open();
    for (int i = 0; i < 256; i++) wall[i] = 1'b0;
  endtask

  task automatic run_solve(input int d);
    int cyc = 0;
    got_path.delete(); got_pushes = 0; got_pops = 0; got_timeout = 0;
    @(negedge clk); start_s[d] = 1'b1;
    @(negedge clk); start_s[d] = 1'b0;
    while (busy_w[d] && cyc < BUDGET) begin
      if (push_w[d]) got_pushes++;
      if (pop_w[d] && !run_w[d]) got_pops++;
      if (pv_w[d]) got_path.push_back(ploc_w[d]);
      @(negedge clk);
      cyc++;
    end
    got_timeout = (cyc >= BUDGET);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clear = 1'b0; start_s[0] = 1'b0; start_s[1] = 1'b0;
    set_open();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy_w[d], found_w[d], nopath_w[d], pv_w[d]} !== 4'b0) begin
        errors++; $display("FAIL reset_status dut%0d got %b want 0000", d,
                           {busy_w[d], found_w[d], nopath_w[d], pv_w[d]});
      end
      checks++;
      if ({wr_w[d], push_w[d], pop_w[d], done_w[d], run_w[d]} !== 5'b0) begin
        errors++; $display("FAIL reset_strobes dut%0d got %b want 00000", d,
                           {wr_w[d], push_w[d], pop_w[d], done_w[d], run_w[d]});
      end
      checks++;
      if ({mem_addr_w[d], loc_in_w[d], ploc_w[d]} !== 24'h0) begin
        errors++; $display("FAIL reset_buses dut%0d got %h want 000000", d,
                           {mem_addr_w[d], loc_in_w[d], ploc_w[d]});
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_open_maze();
    set_open(); clear_mem();
    model_solve(0, 0, 15, 15);
    run_solve(0);
    checks++; if (got_timeout) begin errors++; $display("FAIL open_timeout got busy want idle"); end
    checks++; if (found_w[0] !== 1'b1) begin errors++; $display("FAIL open_found got %b want 1", found_w[0]); end
    checks++; if (nopath_w[0] !== 1'b0) begin errors++; $display("FAIL open_no_path got %b want 0", nopath_w[0]); end
    checks++; if (got_path.size() != 31) begin errors++; $display("FAIL open_beats got %0d want 31", got_path.size()); end
    checks++;
    if (got_path.size() == 31) begin
      int bad = 0;
      for (int i = 0; i < 31; i++) begin
        logic [7:0] want;
        want = (i < 16) ? 8'(i * 16) : 8'(8'hF0 + (i - 15));
        if (got_path[i] !== want) bad++;
      end
      if (bad != 0) begin errors++; $display("FAIL open_path got %0d wrong entries want 0", bad); end
    end else begin
      errors++; $display("FAIL open_path got %0d entries want 31", got_path.size());
    end
    checks++; if (got_pushes != exp_pushes) begin errors++; $display("FAIL open_pushes got %0d want %0d", got_pushes, exp_pushes); end
    checks++; if (got_pops != 0) begin errors++; $display("FAIL open_back_pops got %0d want 0", got_pops); end
`ifdef MAZE_STEP_CNT_EN
    checks++; if (step_w[0] !== 16'd30) begin errors++; $display("FAIL open_step_cnt got %0d want 30", step_w[0]); end
`endif
  endtask

  task automatic test_wall_column();
    set_open();
    for (int y = 0; y < 16; y++) wall[8 * 16 + y] = 1'b1;
    clear_mem();
    model_solve(0, 0, 15, 15);
    run_solve(0);
    checks++; if (got_timeout) begin errors++; $display("FAIL wall_timeout got busy want idle"); end
    checks++; if (nopath_w[0] !== 1'b1) begin errors++; $display("FAIL wall_no_path got %b want 1", nopath_w[0]); end
    checks++; if (found_w[0] !== 1'b0) begin errors++; $display("FAIL wall_found got %b want 0", found_w[0]); end
    checks++; if (got_path.size() != 0) begin errors++; $display("FAIL wall_beats got %0d want 0", got_path.size()); end
    checks++; if (got_pops != exp_pops) begin errors++; $display("FAIL wall_back_pops got %0d want %0d", got_pops, exp_pops); end
    checks++; if (got_pushes != exp_pushes) begin errors++; $display("FAIL wall_pushes got %0d want %0d", got_pushes, exp_pushes); end
`ifdef MAZE_STEP_CNT_EN
    checks++;
    if (step_w[0] !== 16'(exp_moves + exp_backs)) begin
      errors++; $display("FAIL wall_step_cnt got %0d want %0d", step_w[0], exp_moves + exp_backs);
    end
`endif
  endtask

  task automatic test_dead_end();
    bit has10 = 0;
    set_open();
    wall[8'h20] = 1'b1;
    wall[8'h11] = 1'b1;
    clear_mem();
    model_solve(0, 0, 15, 15);
    run_solve(0);
    foreach (got_path[i]) if (got_path[i] == 8'h10) has10 = 1;
    checks++; if (found_w[0] !== 1'b1) begin errors++; $display("FAIL dead_found got %b want 1", found_w[0]); end
    checks++; if (got_pops != 2) begin errors++; $display("FAIL dead_back_pops got %0d want 2", got_pops); end
    checks++;
    if (got_path.size() < 2 || got_path[0] !== 8'h00 || got_path[1] !== 8'h01) begin
      errors++; $display("FAIL dead_path_head got size %0d want 00,01 first", got_path.size());
    end
    checks++; if (has10) begin errors++; $display("FAIL dead_no_10 got 10 in path want absent"); end
    checks++; if (path_diff() != 0) begin errors++; $display("FAIL dead_path got %0d diffs want 0", path_diff()); end
  endtask

  task automatic test_start_is_goal();
    set_open(); clear_mem();
    run_solve(1);
    checks++; if (got_timeout) begin errors++; $display("FAIL sg_timeout got busy want idle"); end
    checks++; if (found_w[1] !== 1'b1) begin errors++; $display("FAIL sg_found got %b want 1", found_w[1]); end
    checks++; if (got_path.size() != 1) begin errors++; $display("FAIL sg_beats got %0d want 1", got_path.size()); end
    checks++;
    if (got_path.size() < 1 || got_path[0] !== 8'h00) begin
      errors++; $display("FAIL sg_loc got size %0d want single 00", got_path.size());
    end
    checks++; if (got_pushes != 1) begin errors++; $display("FAIL sg_pushes got %0d want 1", got_pushes); end
  endtask

  task automatic test_random_mazes();
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) wall[i] = ($urandom_range(0, 99) < 28);
      wall[0] = 1'b0; wall[255] = 1'b0;
      clear_mem();
      model_solve(0, 0, 15, 15);
      run_solve(0);
      checks++; if (got_timeout) begin errors++; $display("FAIL rnd%0d_timeout got busy want idle", t); end
      checks++;
      if (found_w[0] !== exp_found || nopath_w[0] !== exp_nopath) begin
        errors++; $display("FAIL rnd%0d_result got found=%b no_path=%b want found=%b no_path=%b",
                           t, found_w[0], nopath_w[0], exp_found, exp_nopath);
      end
      checks++; if (path_diff() != 0) begin errors++; $display("FAIL rnd%0d_path got %0d diffs want 0", t, path_diff()); end
      checks++;
      if (got_pushes != exp_pushes || got_pops != exp_pops) begin
        errors++; $display("FAIL rnd%0d_stack got push=%0d pop=%0d want push=%0d pop=%0d",
                           t, got_pushes, got_pops, exp_pushes, exp_pops);
      end
`ifdef MAZE_STEP_CNT_EN
      checks++;
      if (step_w[0] !== 16'(exp_moves + exp_backs)) begin
        errors++; $display("FAIL rnd%0d_step_cnt got %0d want %0d", t, step_w[0], exp_moves + exp_backs);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_move();
    int cyc = 0;
    set_open(); clear_mem();
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    while (!(wr_w[0] && push_w[0] && loc_in_w[0] != 8'h00) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    checks++; if (cyc >= 200) begin errors++; $display("FAIL mid_reach_move got timeout want MOVE"); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy_w[0], found_w[0], nopath_w[0], pv_w[0], wr_w[0], push_w[0], pop_w[0], done_w[0], run_w[0]} !== 9'b0) begin
      errors++; $display("FAIL mid_reset_ctrl got %b want 0",
        {busy_w[0], found_w[0], nopath_w[0], pv_w[0], wr_w[0], push_w[0], pop_w[0], done_w[0], run_w[0]});
    end
    checks++;
    if ({mem_addr_w[0], loc_in_w[0], ploc_w[0]} !== 24'h0) begin
      errors++; $display("FAIL mid_reset_buses got %h want 000000", {mem_addr_w[0], loc_in_w[0], ploc_w[0]});
    end
    @(negedge clk); rst = 1'b0;
    clear_mem();
    model_solve(0, 0, 15, 15);
    run_solve(0);
    checks++; if (found_w[0] !== 1'b1) begin errors++; $display("FAIL mid_resolve_found got %b want 1", found_w[0]); end
    checks++; if (path_diff() != 0) begin errors++; $display("FAIL mid_resolve_path got %0d diffs want 0", path_diff()); end
  endtask

  initial begin
    test_reset();
    test_open_maze();
    test_wall_column();
    test_dead_end();
    test_start_is_goal();
    test_random_mazes();
    test_reset_mid_move();
    checks++; if (g_dut[0].viol != 0) begin errors++; $display("FAIL strobe_rules dut0 got %0d violations want 0", g_dut[0].viol); end
    checks++; if (g_dut[1].viol != 0) begin errors++; $display("FAIL strobe_rules dut1 got %0d violations want 0", g_dut[1].viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
